// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// Multiply-accumulate front end for the tanh activation stage. For each
// evaluation it takes N signed Q5.26 activation/weight pairs over a
// valid/ready stream. It adds their products to a Q5.26 bias, saturates the
// sum to Q5.26 and presents the result on ox using the tanh stage's wait (wa)
// handshake.
//
// Ports
//   clk       in   rising-edge system clock
//   rst       in   synchronous active-high reset
//   start     in   begins an evaluation when idle (ignored while busy)
//   bias      in   Q5.26 bias, sampled when start is accepted
//   in_valid  in   x_in/w_in carry a valid pair
//   in_ready  out  a pair is accepted this cycle (high only while accumulating)
//   x_in      in   Q5.26 activation
//   w_in      in   Q5.26 weight
//   ox        out  saturated Q5.26 pre-activation
//   wa        out  1 = tanh stage waits, 0 = ox valid
//   tanh_en   in   tanh stage acknowledge of ox
//   busy      out  evaluation in progress
//   ovf       out  last result saturated (meaningful while wa=0)
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int N      = 4,
  parameter int FRAC   = 26,
  parameter int ACC_W  = 48,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  output logic signed [DATA_W-1:0] ox,
  output logic                     wa,
  input  logic                     tanh_en,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_SAT,
    S_PRESENT
  } state_t;

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  // Q5.26 representable range expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     r_state;
  logic signed [ACC_W-1:0]    r_acc;
  logic [7:0]                 r_count;
  logic signed [PROD_W-1:0]   r_prod_p0;
  logic                       r_vld_p0;
  logic signed [DATA_W-1:0]   r_ox;
  logic                       r_wa;
  logic                       r_ovf;

  logic                       w_xfer;
  logic signed [PROD_W-1:0]   w_x_ext;
  logic signed [PROD_W-1:0]   w_w_ext;
  logic signed [ACC_W-1:0]    w_prod_sh;
  logic signed [ACC_W-1:0]    w_bias_ext;

  // Rescale a full-precision Q10.52 product back to Q.26 at accumulator
  // width. Arithmetic shift truncates toward minus infinity.
  function automatic logic signed [ACC_W-1:0] rescale(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W-1:0] s;
    s = p >>> FRAC;
    return s[ACC_W-1:0];
  endfunction

  // Clamp accumulator to Q5.26; returns {overflow flag, result}.
  function automatic logic [DATA_W:0] sat_q(
    input logic signed [ACC_W-1:0] a
  );
    if (a > SAT_MAX) begin
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end else if (a < SAT_MIN) begin
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, a[DATA_W-1:0]};
    end
  endfunction

  assign in_ready   = (r_state == S_ACC);
  assign busy       = (r_state != S_IDLE);
  assign ox         = r_ox;
  assign wa         = r_wa;
  assign ovf        = r_ovf;

  assign w_xfer     = in_valid && (r_state == S_ACC);
  assign w_x_ext    = PROD_W'(x_in);
  assign w_w_ext    = PROD_W'(w_in);
  assign w_prod_sh  = rescale(r_prod_p0);
  assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

  // ---- stage p0: product register (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_prod_p0 <= w_x_ext * w_w_ext;
    end
  end

  // ---- stage p1: accumulate, control FSM, saturate and present ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_vld_p0 <= 1'b0;
      r_ox     <= '0;
      r_wa     <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_vld_p0 <= w_xfer;
      // The product registered last cycle is folded in here; this also
      // covers the final product during DRAIN. r_vld_p0 is never set in IDLE,
      // so it cannot collide with the bias load below.
      if (r_vld_p0) begin
        r_acc <= r_acc + w_prod_sh;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= w_bias_ext;
            r_count <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            r_count <= r_count + 8'd1;
            if (r_count == LAST_IDX) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_SAT;
        end
        S_SAT: begin
          {r_ovf, r_ox} <= sat_q(r_acc);
          r_wa          <= 1'b0;
          r_state       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (tanh_en) begin
            r_wa    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
// Directed bench for neuron_mac. A behavioural model computes the saturated
// bias + sum(floor(x*w / 2^26)) with 64-bit integer arithmetic. A negedge
// compare process checks ox/ovf against that model whenever wa is low, and the
// directed cases also check literal hand-computed values.
// -----------------------------------------------------------------------------
module tb_neuron_mac;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        tanh_en = 1'b0;
  logic [31:0] bias = '0;
  logic [31:0] x_in = '0;
  logic [31:0] w_in = '0;
  logic [31:0] ox;
  logic        in_ready;
  logic        wa;
  logic        busy;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ox = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_valid = 1'b0;

  neuron_mac #(.N(N), .FRAC(26), .ACC_W(48)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .ox       (ox),
    .wa       (wa),
    .tanh_en  (tanh_en),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: Q5.26 MAC with floor rescale and saturation; {ovf, ox}.
  function automatic logic [32:0] model(input logic [31:0] b,
                                        input logic [31:0] xs [N],
                                        input logic [31:0] ws [N]);
    longint acc;
    acc = longint'(signed'(b));
    for (int i = 0; i < N; i++) begin
      acc += (longint'(signed'(xs[i])) * longint'(signed'(ws[i]))) >>> 26;
    end
    if (acc > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (acc < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, acc[31:0]};
  endfunction

  // Continuous check while a result is presented.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_only_when_busy", 32'(in_ready & ~busy), 32'd0);
      if (!wa) begin
        chk("wa_low_expected", 32'(exp_valid), 32'd1);
        chk("ox_vs_model", ox, exp_ox);
        chk("ovf_vs_model", 32'(ovf), 32'(exp_ovf));
        chk("busy_in_present", 32'(busy), 32'd1);
        chk("in_ready_in_present", 32'(in_ready), 32'd0);
      end
    end
  end

  // Start an evaluation and transfer npairs pairs. Inputs change #1 after
  // the rising edge; a pair counts as transferred when in_valid and in_ready
  // are both high at the edge.
  task automatic feed(input logic [31:0] b, input logic [31:0] xs [N],
                      input logic [31:0] ws [N], input bit gaps,
                      input int npairs);
    int   i;
    int   guard;
    logic rdy;
    i = 0;
    guard = 0;
    {exp_ovf, exp_ox} = model(b, xs, ws);
    exp_valid = 1'b1;
    bias  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bias  = $urandom;
    while (i < npairs && guard < 200) begin
      guard++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gaps) start = 1'($urandom_range(0, 1));
      x_in = in_valid ? xs[i] : $urandom;
      w_in = in_valid ? ws[i] : $urandom;
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tanh_en  = 1'b0;
    x_in     = $urandom;
    w_in     = $urandom;
    chk("pairs_transferred", 32'(i), 32'(npairs));
  endtask

  // Two edges after the last-transfer edge wa must be low (cycle T+3).
  task automatic result(input string name, input logic [31:0] lit_ox,
                        input logic lit_ovf);
    int k;
    k = 0;
    chk({name, "_in_ready_drop"}, 32'(in_ready), 32'd0);
    while (wa && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_latency"}, 32'(k), 32'd2);
    chk({name, "_model_lit"}, exp_ox, lit_ox);
    chk({name, "_ox_lit"}, ox, lit_ox);
    chk({name, "_ovf_lit"}, 32'(ovf), 32'(lit_ovf));
  endtask

  task automatic ack(input int hold);
    logic [31:0] ox0;
    ox0 = ox;
    tanh_en = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    chk("hold_ox", ox, ox0);
    chk("hold_wa", 32'(wa), 32'd0);
    tanh_en = 1'b1;
    @(posedge clk);
    #1;
    tanh_en = 1'b0;
    chk("ack_wa", 32'(wa), 32'd1);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_ox_holds", ox, ox0);
    exp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] xs [N];
    logic [31:0] ws [N];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ox", ox, 32'h0);
    chk("rst_wa", 32'(wa), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 * 0.5 four times -> 2.0
    xs = '{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
    ws = '{32'h0200_0000, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};
    feed(32'h0, xs, ws, 1'b0, N);
    result("c1", 32'h0800_0000, 1'b0);
    ack(2);

    // -1.0 * 1.0 four times + 0.5, with tanh_en asserted outside PRESENT
    xs = '{32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000};
    ws = '{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
    tanh_en = 1'b1;
    feed(32'h0200_0000, xs, ws, 1'b0, N);
    result("c2", 32'hF200_0000, 1'b0);
    ack(2);

    // Positive and negative saturation
    xs = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    ws = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    feed(32'h0, xs, ws, 1'b0, N);
    result("c3_pos", 32'h7FFF_FFFF, 1'b1);
    ack(1);
    ws = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};
    feed(32'h0, xs, ws, 1'b0, N);
    result("c3_neg", 32'h8000_0000, 1'b1);
    ack(1);

    // Rescale truncates toward -inf: (2^-26 * -2^-26) >> 26 = -1 LSB each
    xs = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    ws = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    feed(32'h0, xs, ws, 1'b0, N);
    result("trunc", 32'hFFFF_FFFC, 1'b0);
    ack(1);

    // Exactly full scale does not saturate; one LSB more does
    xs = '{32'h0, 32'h0, 32'h0, 32'h0};
    ws = '{32'h0, 32'h0, 32'h0, 32'h0};
    feed(32'h7FFF_FFFF, xs, ws, 1'b0, N);
    result("edge_max", 32'h7FFF_FFFF, 1'b0);
    ack(1);
    xs = '{32'h0400_0000, 32'h0, 32'h0, 32'h0};
    ws = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
    feed(32'h7FFF_FFFF, xs, ws, 1'b0, N);
    result("edge_over", 32'h7FFF_FFFF, 1'b1);
    ack(1);

    // Case 1 with random in_valid gaps and stray start pulses
    xs = '{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
    ws = '{32'h0200_0000, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};
    feed(32'h0, xs, ws, 1'b1, N);
    result("c4_gaps", 32'h0800_0000, 1'b0);

    // Long hold in PRESENT
    ack(100);

    // Reset after two pairs discards the partial sum
    feed(32'h0, xs, ws, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("c6_rst_ox", ox, 32'h0);
    chk("c6_rst_wa", 32'(wa), 32'd1);
    chk("c6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("c6_rst_busy", 32'(busy), 32'd0);
    chk("c6_rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    feed(32'h0, xs, ws, 1'b0, N);
    result("c6_fresh", 32'h0800_0000, 1'b0);
    ack(1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
